// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 16-bit 5-stage pipeline: combinational PC/IF/ID/ID-EX controls
// from a RUN/DRAIN/HALTED state machine, plus saturating stall and flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 2,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             if_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use_s;
    logic             inc_stall_s;
    logic             inc_flush_s;

    assign load_use_s = ex_mem_read &
                        ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    // Next-state and pipeline control decode; reset forces the safe bubble pattern.
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        if_flush      = 1'b0;
        idex_bubble   = 1'b0;
        inc_stall_s   = 1'b0;
        inc_flush_s   = 1'b0;
        if (reset) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            state_d       = ST_RUN;
            drain_d       = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        if_flush    = 1'b1;
                        idex_bubble = 1'b1;
                        inc_flush_s = 1'b1;
                    end else if (id_halt) begin
                        // HLT itself moves on to EX; fetch freezes behind it
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        inc_stall_s   = 1'b1;
                        state_d       = ST_DRAIN;
                        drain_d       = DRAIN_INIT;
                    end else if (load_use_s) begin
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        idex_bubble   = 1'b1;
                        inc_stall_s   = 1'b1;
                    end else if (id_jump) begin
                        if_flush    = 1'b1;
                        inc_flush_s = 1'b1;
                    end else if (!imem_ready) begin
                        pc_write_en = 1'b0;
                        if_flush    = 1'b1;
                        inc_stall_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (ex_branch_taken) begin
                        if_flush    = 1'b1;
                        idex_bubble = 1'b1;
                        inc_flush_s = 1'b1;
                        state_d     = ST_RUN;
                        drain_d     = '0;
                    end else begin
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        idex_bubble   = 1'b1;
                        drain_d       = drain_q - DRAIN_LAST;
                        if (drain_q == DRAIN_LAST) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_HALTED: begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                end
                default: begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                    state_d       = ST_RUN;
                    drain_d       = '0;
                end
            endcase
        end
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (reset) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (inc_stall_s && (stall_q != CNT_MAX)) begin
                stall_d = stall_q + CNT_ONE;
            end else begin
                stall_d = stall_q;
            end
            if (inc_flush_s && (flush_q != CNT_MAX)) begin
                flush_d = flush_q + CNT_ONE;
            end else begin
                flush_d = flush_q;
            end
        end
    end

    // State, drain counter and performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign halted       = (state_q == ST_HALTED) & ~reset;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed scenarios then random traffic into two builds (default and
// CNT_W=4/DRAIN_CYCLES=1), checked against an abstract pipeline-sequencer model.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        bit       reset;
        bit [1:0] rs;
        bit [1:0] rt;
        bit       urs;
        bit       urt;
        bit       jump;
        bit       halt;
        bit       mr;
        bit [1:0] rd;
        bit       br;
        bit       imem;
    } in_t;

    typedef struct packed {
        bit halted;
        int drain_left;
        int stall;
        int flc;
    } m_t;

    typedef struct packed {
        bit pc;
        bit ifid;
        bit fl;
        bit bub;
        bit hal;
        int stall;
        int flc;
        bit cv;
    } out_t;

    typedef struct packed {
        out_t a;
        out_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, id_jump, id_halt, ex_mem_read, ex_branch_taken, imem_ready;
    logic       a_pc, a_ifid, a_fl, a_bub, a_hal;
    logic [15:0] a_stall, a_flc;
    logic       b_pc, b_ifid, b_fl, b_bub, b_hal;
    logic [3:0] b_stall, b_flc;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    m_t   ma, mb;
    bit   cnt_known = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(2), .CNT_W(16), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump), .id_halt(id_halt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready), .pc_write_en(a_pc), .ifid_write_en(a_ifid), .if_flush(a_fl),
        .idex_bubble(a_bub), .halted(a_hal), .stall_cycles(a_stall), .flush_count(a_flc));

    pipeline_hazard_ctrl #(.REG_W(2), .CNT_W(4), .DRAIN_CYCLES(1)) dut4 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_jump(id_jump), .id_halt(id_halt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready), .pc_write_en(b_pc), .ifid_write_en(b_ifid), .if_flush(b_fl),
        .idex_bubble(b_bub), .halted(b_hal), .stall_cycles(b_stall), .flush_count(b_flc));

    // Reference: what one pipeline-control cycle does, from the priority rules.
    function automatic void model_step(input int dc, input int cmax, input m_t c, input in_t i,
                                       output m_t n, output out_t o);
        bit lu;
        bit do_stall;
        bit do_flush;
        n = c;
        o = '{pc: 1'b1, ifid: 1'b1, fl: 1'b0, bub: 1'b0, hal: c.halted,
              stall: c.stall, flc: c.flc, cv: 1'b1};
        do_stall = 1'b0;
        do_flush = 1'b0;
        lu = i.mr && ((i.urs && i.rs == i.rd) || (i.urt && i.rt == i.rd));
        if (i.reset) begin
            o.pc = 1'b0; o.ifid = 1'b0; o.bub = 1'b1; o.hal = 1'b0;
            n = '{halted: 1'b0, drain_left: 0, stall: 0, flc: 0};
            return;
        end
        if (c.halted) begin
            o.pc = 1'b0; o.ifid = 1'b0; o.bub = 1'b1;
        end else if (c.drain_left > 0) begin
            if (i.br) begin
                o.fl = 1'b1; o.bub = 1'b1; do_flush = 1'b1; n.drain_left = 0;
            end else begin
                o.pc = 1'b0; o.ifid = 1'b0; o.bub = 1'b1;
                n.drain_left = c.drain_left - 1;
                n.halted = (n.drain_left == 0);
            end
        end else if (i.br) begin
            o.fl = 1'b1; o.bub = 1'b1; do_flush = 1'b1;
        end else if (i.halt) begin
            o.pc = 1'b0; o.ifid = 1'b0; do_stall = 1'b1; n.drain_left = dc;
        end else if (lu) begin
            o.pc = 1'b0; o.ifid = 1'b0; o.bub = 1'b1; do_stall = 1'b1;
        end else if (i.jump) begin
            o.fl = 1'b1; do_flush = 1'b1;
        end else if (!i.imem) begin
            o.pc = 1'b0; o.fl = 1'b1; do_stall = 1'b1;
        end
        if (do_stall) n.stall = (c.stall < cmax) ? c.stall + 1 : cmax;
        if (do_flush) n.flc = (c.flc < cmax) ? c.flc + 1 : cmax;
    endfunction

    function automatic in_t idle();
        in_t t;
        t = '0;
        t.imem = 1'b1;
        return t;
    endfunction

    task automatic drive(input in_t t);
        exp_t e;
        m_t   na, nb;
        @(posedge clk);
        #1;
        reset = t.reset; id_rs = t.rs; id_rt = t.rt; id_uses_rs = t.urs; id_uses_rt = t.urt;
        id_jump = t.jump; id_halt = t.halt; ex_mem_read = t.mr; ex_rd = t.rd;
        ex_branch_taken = t.br; imem_ready = t.imem;
        model_step(3, 65535, ma, t, na, e.a);
        model_step(1, 15, mb, t, nb, e.b);
        e.a.cv = cnt_known;
        e.b.cv = cnt_known;
        cnt_known = 1'b1;
        ma = na;
        mb = nb;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected record per cycle and compares both builds mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("a_pc_we", int'(a_pc), int'(e.a.pc));
            chk("a_ifid_we", int'(a_ifid), int'(e.a.ifid));
            chk("a_if_flush", int'(a_fl), int'(e.a.fl));
            chk("a_bubble", int'(a_bub), int'(e.a.bub));
            chk("a_halted", int'(a_hal), int'(e.a.hal));
            chk("b_pc_we", int'(b_pc), int'(e.b.pc));
            chk("b_ifid_we", int'(b_ifid), int'(e.b.ifid));
            chk("b_if_flush", int'(b_fl), int'(e.b.fl));
            chk("b_bubble", int'(b_bub), int'(e.b.bub));
            chk("b_halted", int'(b_hal), int'(e.b.hal));
            if (e.a.cv) begin
                chk("a_stall_cycles", int'(a_stall), e.a.stall);
                chk("a_flush_count", int'(a_flc), e.a.flc);
                chk("b_stall_cycles", int'(b_stall), e.b.stall);
                chk("b_flush_count", int'(b_flc), e.b.flc);
            end
        end
    end

    initial begin
        in_t t;
        int  wait_cyc;
        reset = 1'b1; id_rs = 2'd0; id_rt = 2'd0; ex_rd = 2'd0; id_uses_rs = 1'b0;
        id_uses_rt = 1'b0; id_jump = 1'b0; id_halt = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; imem_ready = 1'b1;
        ma = '0;
        mb = '0;
        t = idle(); t.reset = 1'b1;
        repeat (3) drive(t);
        drive(idle());
        // load-use on rs
        t = idle(); t.mr = 1'b1; t.rd = 2'd2; t.rs = 2'd2; t.urs = 1'b1;
        drive(t);
        drive(idle());
        // jump while fetch waits
        t = idle(); t.jump = 1'b1; t.imem = 1'b0;
        drive(t);
        drive(idle());
        // branch beats a simultaneous load-use
        t = idle(); t.br = 1'b1; t.mr = 1'b1; t.rd = 2'd1; t.rt = 2'd1; t.urt = 1'b1;
        drive(t);
        drive(idle());
        // halt and full drain, then stay halted despite traffic
        t = idle(); t.halt = 1'b1;
        drive(t);
        repeat (6) drive(idle());
        t = idle(); t.br = 1'b1; t.jump = 1'b1;
        drive(t);
        t = idle(); t.reset = 1'b1;
        drive(t);
        // halt, then branch cancels drain two cycles later
        t = idle(); t.halt = 1'b1;
        drive(t);
        drive(idle());
        t = idle(); t.br = 1'b1;
        drive(t);
        repeat (4) drive(idle());
        // 20 stall cycles saturate the 4-bit counters, then reset clears them
        t = idle(); t.reset = 1'b1;
        drive(t);
        t = idle(); t.imem = 1'b0;
        repeat (20) drive(t);
        t = idle(); t.jump = 1'b1;
        repeat (20) drive(t);
        drive(idle());
        t = idle(); t.reset = 1'b1;
        drive(t);
        drive(idle());
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            t.reset = ($urandom_range(0, 49) == 0);
            t.rs    = 2'($urandom_range(0, 3));
            t.rt    = 2'($urandom_range(0, 3));
            t.rd    = 2'($urandom_range(0, 3));
            t.urs   = 1'($urandom_range(0, 1));
            t.urt   = 1'($urandom_range(0, 1));
            t.mr    = ($urandom_range(0, 2) == 0);
            t.jump  = ($urandom_range(0, 5) == 0);
            t.halt  = ($urandom_range(0, 29) == 0);
            t.br    = ($urandom_range(0, 7) == 0);
            t.imem  = ($urandom_range(0, 4) != 0);
            drive(t);
        end
        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain_scoreboard actual=%0d expected=0 entries left", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
